sh_sequencer: RTL and testbench

//  Digital timing controller placed directly upstream of the sample_and_hold analog macro.

---
 rtl/sh_sequencer.sv | 85 ++++++++
 tb/tb_sh_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sh_sequencer.sv
// sh_sequencer: sequences the sample_and_hold ena/hold pins through wake, acquire and settle,
// then holds the settled sample for the ADC with a conv_req/conv_ack handshake.
module sh_sequencer #(
    parameter int WAKE_CYC   = 8,
    parameter int TRACK_CYC  = 4,
    parameter int SETTLE_CYC = 2,
    parameter int PW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          start,
    input  logic          auto_mode,
    input  logic [PW-1:0] period,
    input  logic          conv_ack,
    input  logic          clr_overrun,
    output logic          sh_ena,
    output logic          sh_hold,
    output logic          conv_req,
    output logic          busy,
    output logic          overrun
);
    localparam int MX = (WAKE_CYC > TRACK_CYC) ? ((WAKE_CYC > SETTLE_CYC) ? WAKE_CYC : SETTLE_CYC)
                                               : ((TRACK_CYC > SETTLE_CYC) ? TRACK_CYC : SETTLE_CYC);
    localparam int CW = $clog2(MX + 1);

    typedef enum logic [2:0] {OFF, WAKE, IDLE, ACQ, SETTLE, CONV} state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [PW-1:0] tmr, period_q;
    logic          auto_q;
    logic          run, restart, tick, trig, ovr_set;

    assign run     = enable && auto_mode && period != '0;
    assign restart = period != period_q || auto_mode != auto_q;
    assign tick    = run && !restart && tmr == period - PW'(1);
    assign trig    = auto_mode ? tick : start;
    assign ovr_set = enable && trig && state inside {WAKE, ACQ, SETTLE, CONV};

    // cnt counts down to 0 from (cycles-1), loaded on entry to each timed state
    always_comb begin
        nxt     = state;
        cnt_nxt = (cnt != '0) ? cnt - 1'b1 : cnt;
        case (state)
            OFF:     if (enable) begin nxt = WAKE; cnt_nxt = CW'(WAKE_CYC - 1); end
            WAKE:    if (cnt == '0) nxt = IDLE;
            IDLE:    if (trig) begin nxt = ACQ; cnt_nxt = CW'(TRACK_CYC - 1); end
            ACQ:     if (cnt == '0) begin nxt = SETTLE; cnt_nxt = CW'(SETTLE_CYC - 1); end
            SETTLE:  if (cnt == '0) nxt = CONV;
            CONV:    if (conv_req && conv_ack) nxt = IDLE;
            default: nxt = OFF;
        endcase
        if (!enable) begin
            nxt     = OFF;
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= OFF;
            cnt      <= '0;
            tmr      <= '0;
            period_q <= '0;
            auto_q   <= 1'b0;
            sh_ena   <= 1'b0;
            sh_hold  <= 1'b0;
            conv_req <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= nxt;
            cnt      <= cnt_nxt;
            tmr      <= (!run || restart || tick) ? '0 : tmr + 1'b1;
            period_q <= period;
            auto_q   <= auto_mode;
            sh_ena   <= nxt != OFF;
            sh_hold  <= nxt == SETTLE || nxt == CONV;
            conv_req <= nxt == CONV;
            busy     <= nxt inside {ACQ, SETTLE, CONV};
            overrun  <= ovr_set || (overrun && !clr_overrun);
        end
    end
endmodule

// File: tb/tb_sh_sequencer.sv
// tb_sh_sequencer: directed scenarios for sh_sequencer with hand-computed cycle timing.
module tb_sh_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0, start = 1'b0, auto_mode = 1'b0, conv_ack = 1'b0, clr_overrun = 1'b0;
    logic [15:0] period = '0;
    logic        sh_ena, sh_hold, conv_req, busy, overrun;
    logic [3:0]  o;
    int          cmps = 0, errs = 0;

    assign o = {sh_ena, sh_hold, conv_req, busy};

    always #5 clk = ~clk;

    sh_sequencer dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .auto_mode(auto_mode),
        .period(period), .conv_ack(conv_ack), .clr_overrun(clr_overrun),
        .sh_ena(sh_ena), .sh_hold(sh_hold), .conv_req(conv_req), .busy(busy), .overrun(overrun)
    );

    // advance n rising edges, leaving time 1ns after the last one
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        step(3);
        cmps++; if (o !== 4'b0000) begin errs++; $display("FAIL reset_outs: got %b want 0000", o); end
        cmps++; if (overrun !== 1'b0) begin errs++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        rst = 1'b0;
        step(2);
        cmps++; if (o !== 4'b0000) begin errs++; $display("FAIL off_idle: got %b want 0000", o); end
    endtask

    task automatic test_single;
        enable = 1'b1;
        step(1);
        cmps++; if (o !== 4'b1000) begin errs++; $display("FAIL wake_outs: got %b want 1000", o); end
        step(9);
        start = 1'b1;
        step(1);
        start = 1'b0;
        cmps++; if (o !== 4'b1001) begin errs++; $display("FAIL acq_entry: got %b want 1001", o); end
        step(3);
        cmps++; if (o !== 4'b1001) begin errs++; $display("FAIL acq_last: got %b want 1001", o); end
        step(1);
        cmps++; if (o !== 4'b1101) begin errs++; $display("FAIL settle_entry: got %b want 1101", o); end
        step(1);
        cmps++; if (o !== 4'b1101) begin errs++; $display("FAIL settle_last: got %b want 1101", o); end
        step(1);
        cmps++; if (o !== 4'b1111) begin errs++; $display("FAIL conv_entry: got %b want 1111", o); end
        step(2);
        cmps++; if (o !== 4'b1111) begin errs++; $display("FAIL conv_wait: got %b want 1111", o); end
        conv_ack = 1'b1;
        step(1);
        conv_ack = 1'b0;
        cmps++; if (o !== 4'b1000) begin errs++; $display("FAIL after_ack: got %b want 1000", o); end
        cmps++; if (overrun !== 1'b0) begin errs++; $display("FAIL single_ovr: got %b want 0", overrun); end
    endtask

    task automatic test_auto20;
        int rises[$];
        logic prev = 1'b0;
        auto_mode = 1'b1;
        period = 16'd20;
        for (int i = 1; i <= 130; i++) begin
            step(1);
            if (conv_req && !prev) rises.push_back(i);
            prev = conv_req;
            conv_ack = conv_req;
        end
        conv_ack = 1'b0;
        auto_mode = 1'b0;
        period = '0;
        cmps++; if (rises.size() != 6) begin errs++; $display("FAIL auto20_count: got %0d want 6", rises.size()); end
        if (rises.size() > 0) begin
            cmps++; if (rises[0] != 27) begin errs++; $display("FAIL auto20_first: got %0d want 27", rises[0]); end
        end
        for (int i = 1; i < rises.size(); i++) begin
            cmps++;
            if (rises[i] - rises[i-1] != 20) begin
                errs++; $display("FAIL auto20_gap%0d: got %0d want 20", i, rises[i] - rises[i-1]);
            end
        end
        cmps++; if (overrun !== 1'b0) begin errs++; $display("FAIL auto20_ovr: got %b want 0", overrun); end
    endtask

    task automatic test_overrun;
        int rises[$];
        logic prev = 1'b0;
        auto_mode = 1'b1;
        period = 16'd5;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (conv_req && !prev) rises.push_back(i);
            prev = conv_req;
            conv_ack = conv_req;
        end
        auto_mode = 1'b0;
        period = '0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            conv_ack = conv_req;
        end
        cmps++; if (rises.size() != 3) begin errs++; $display("FAIL p5_count: got %0d want 3", rises.size()); end
        if (rises.size() == 3) begin
            cmps++; if (rises[0] != 12) begin errs++; $display("FAIL p5_first: got %0d want 12", rises[0]); end
            cmps++; if (rises[2] - rises[1] != 10) begin errs++; $display("FAIL p5_gap: got %0d want 10", rises[2] - rises[1]); end
        end
        cmps++; if (o !== 4'b1000) begin errs++; $display("FAIL p5_done: got %b want 1000", o); end
        cmps++; if (overrun !== 1'b1) begin errs++; $display("FAIL p5_ovr: got %b want 1", overrun); end
        clr_overrun = 1'b1;
        step(1);
        clr_overrun = 1'b0;
        cmps++; if (overrun !== 1'b0) begin errs++; $display("FAIL p5_clr: got %b want 0", overrun); end
    endtask

    task automatic test_disable_conv;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(6);
        cmps++; if (o !== 4'b1111) begin errs++; $display("FAIL dis_conv: got %b want 1111", o); end
        step(2);
        enable = 1'b0;
        step(1);
        cmps++; if (o !== 4'b0000) begin errs++; $display("FAIL dis_off: got %b want 0000", o); end
        enable = 1'b1;
        step(1);
        cmps++; if (o !== 4'b1000) begin errs++; $display("FAIL reen_wake: got %b want 1000", o); end
        step(8);
        start = 1'b1;
        step(1);
        start = 1'b0;
        cmps++; if (o !== 4'b1001) begin errs++; $display("FAIL reen_acq: got %b want 1001", o); end
        cmps++; if (overrun !== 1'b0) begin errs++; $display("FAIL reen_ovr: got %b want 0", overrun); end
        step(5);
        cmps++; if (o !== 4'b1101) begin errs++; $display("FAIL reen_settle: got %b want 1101", o); end
        step(1);
        conv_ack = 1'b1;
        step(1);
        conv_ack = 1'b0;
        cmps++; if (o !== 4'b1000) begin errs++; $display("FAIL reen_ack: got %b want 1000", o); end
    endtask

    task automatic test_wake_start;
        enable = 1'b0;
        step(1);
        enable = 1'b1;
        step(8);
        start = 1'b1;
        clr_overrun = 1'b1;
        step(1);
        start = 1'b0;
        clr_overrun = 1'b0;
        cmps++; if (overrun !== 1'b1) begin errs++; $display("FAIL wake_start_ovr: got %b want 1", overrun); end
        cmps++; if (o !== 4'b1000) begin errs++; $display("FAIL wake_start_noacq: got %b want 1000", o); end
        start = 1'b1;
        enable = 1'b0;
        step(1);
        start = 1'b0;
        cmps++; if (o !== 4'b0000) begin errs++; $display("FAIL start_disable: got %b want 0000", o); end
        cmps++; if (overrun !== 1'b1) begin errs++; $display("FAIL start_disable_ovr: got %b want 1", overrun); end
        clr_overrun = 1'b1;
        step(1);
        clr_overrun = 1'b0;
        cmps++; if (overrun !== 1'b0) begin errs++; $display("FAIL wake_clr: got %b want 0", overrun); end
    endtask

    task automatic test_ack_high;
        int req_cyc = 0;
        enable = 1'b1;
        step(9);
        conv_ack = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (conv_req) req_cyc++;
        end
        cmps++; if (req_cyc != 1) begin errs++; $display("FAIL ack_high_req: got %0d want 1", req_cyc); end
        cmps++; if (o !== 4'b1000) begin errs++; $display("FAIL ack_high_idle: got %b want 1000", o); end
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        cmps++; if (o !== 4'b1101) begin errs++; $display("FAIL pre_rst_settle: got %b want 1101", o); end
        #2 rst = 1'b1;
        #1;
        cmps++; if (o !== 4'b0000) begin errs++; $display("FAIL async_rst: got %b want 0000", o); end
        conv_ack = 1'b0;
        enable = 1'b0;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_auto20();
        test_overrun();
        test_disable_conv();
        test_wake_start();
        test_ack_high();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
